// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg: shared types and constants for the end-of-run memory dump engine.
// Holds the dump FSM state type, cycle-counter width/limit and idx sizing.
package mem_dump_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PUSH    = 3'd3,
    ST_DONE    = 3'd4
  } dump_state_e;

  localparam int CYCLE_CNT_W = 32;
  localparam logic [CYCLE_CNT_W-1:0] CYCLE_CNT_MAX = '1;

  function automatic int unsigned idx_width(int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_dump_if.sv
// mem_dump_if: DM read port takeover plus valid/ready dump stream.
// master = dump engine (drives dump_own, dm_addr, out_*), slave = platform/consumer.
interface mem_dump_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) ();

  logic              dump_own;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_read_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output dump_own,
    output dm_addr,
    input  dm_read_data,
    output out_valid,
    input  out_ready,
    output out_addr,
    output out_data
  );

  modport slave (
    input  dump_own,
    input  dm_addr,
    output dm_read_data,
    input  out_valid,
    output out_ready,
    input  out_addr,
    input  out_data
  );

endinterface

// File: rtl/dump_cycle_counter.sv
// dump_cycle_counter: saturating run-cycle counter with freeze input.
// Ports: clk, rst, freeze in; count, limit_hit out (compare only with MEM_DUMP_WATCHDOG_EN).
module dump_cycle_counter
  import mem_dump_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  output logic [CYCLE_CNT_W-1:0] count,
  output logic                   limit_hit
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!freeze && count != CYCLE_CNT_MAX) begin
      count <= count + 1'b1;
    end
  end

`ifdef MEM_DUMP_WATCHDOG_EN
  assign limit_hit = (count == CYCLE_CNT_W'(TIMEOUT_CYCLES));
`else
  assign limit_hit = 1'b0;
`endif

endmodule

// File: rtl/mem_dump_unit.sv
// mem_dump_unit: waits for halt (or watchdog with MEM_DUMP_WATCHDOG_EN), then dumps
// WORD_COUNT DM words from BASE_ADDR over bus (master); ports clk, rst, halt, done, timeout, cycle_count.
module mem_dump_unit
  import mem_dump_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 16,
  parameter int unsigned       DATA_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int unsigned       WORD_COUNT     = 10,
  parameter int unsigned       TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   halt,
  mem_dump_if.master             bus,
  output logic                   done,
  output logic                   timeout,
  output logic [CYCLE_CNT_W-1:0] cycle_count
);

  localparam logic [2:0] S_RUN     = ST_RUN;
  localparam logic [2:0] S_ISSUE   = ST_ISSUE;
  localparam logic [2:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [2:0] S_PUSH    = ST_PUSH;
  localparam logic [2:0] S_DONE    = ST_DONE;

  localparam int unsigned IDX_W = idx_width(WORD_COUNT);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);
  localparam logic [IDX_W-1:0] LAST =
    (WORD_COUNT == 0) ? '0 : IDX_W'(WORD_COUNT - 1);

  logic [2:0]        state;
  logic [2:0]        state_n;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_n;
  logic              wd_hit;
  logic              trig;
  logic              hs;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;

  // Address wraps modulo 2^ADDR_W by truncation.
  function automatic logic [ADDR_W-1:0] word_addr(logic [IDX_W-1:0] i);
    return BASE_ADDR + ADDR_W'(i) * STRIDE;
  endfunction

  assign trig = halt | wd_hit;
  assign hs   = (state == S_PUSH) & bus.out_ready;

  dump_cycle_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .freeze   ((state != S_RUN) | trig),
    .count    (cycle_count),
    .limit_hit(wd_hit)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_RUN: begin
        if (trig) state_n = (WORD_COUNT == 0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE:   state_n = S_CAPTURE;
      S_CAPTURE: state_n = S_PUSH;
      S_PUSH: begin
        if (hs) state_n = (idx == LAST) ? S_DONE : S_ISSUE;
      end
      S_DONE:    state_n = S_DONE;
      default:   state_n = S_RUN;
    endcase
  end

  assign idx_n = (hs && idx != LAST) ? idx + 1'b1 : idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RUN;
      idx       <= '0;
      dm_addr_q <= '0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      // Registered so it is 0 in reset and BASE_ADDR whenever not issuing.
      dm_addr_q <= (state_n == S_ISSUE) ? word_addr(idx_n) : BASE_ADDR;
      if (state == S_CAPTURE) begin
        hold_addr <= word_addr(idx);
        hold_data <= bus.dm_read_data;
      end
    end
  end

`ifdef MEM_DUMP_WATCHDOG_EN
  // halt has priority when it coincides with the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout <= 1'b0;
    end else if (state == S_RUN && !halt && wd_hit) begin
      timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign bus.dump_own  = (state == S_ISSUE) | (state == S_CAPTURE) |
                         (state == S_PUSH);
  assign bus.out_valid = (state == S_PUSH);
  assign bus.dm_addr   = dm_addr_q;
  assign bus.out_addr  = hold_addr;
  assign bus.out_data  = hold_data;
  assign done          = (state == S_DONE);

endmodule
